tpu_job_ctrl: RTL
=================

// Module: tpu_job_ctrl
// PURPOSE
//  Job sequencer placed in front of the TinyTPU top level. Accepts operand byte pairs from a host
//  over a valid/ready bus and serialises them MSB-first onto data_in_x/data_in_y under load_en.
//  Then pulses init, waits for tx_ready, and deserialises the data_out_z result stream into
//  2*D_W-bit result words. One job is in flight at a time.
// PARAMETERS
//  D_W      8    operand width in bits; result word is 2*D_W
//  N        3    array dimension; result count = N*N words
//  WORD     3    operand beats per array row; total beats BEATS = N*WORD
//  TIMEOUT  1024 WAIT-state watchdog limit in cycles (used only with TPU_CTRL_TIMEOUT_EN)
// PORTS
//  clk         in   1      clock, rising edge
//  rst         in   1      asynchronous reset, active-high
//  start       in   1      job start request, sampled in IDLE only
//  busy        out  1      high in every state except IDLE
//  in_valid    in   1      host operand pair valid
//  in_ready    out  1      controller can accept an operand pair
//  in_x        in   D_W    x operand byte
//  in_y        in   D_W    y operand byte
//  data_in_x   out  1      serial x operand bit to the TPU
//  data_in_y   out  1      serial y operand bit to the TPU
//  load_en     out  1      qualifies data_in_x/data_in_y bits
//  init        out  1      compute trigger, one-cycle pulse
//  data_out_z  in   1      serial result bit from the TPU
//  tx_ready    in   1      TPU result stream active
//  res_valid   out  1      one-cycle strobe: res_data holds a new word
//  res_data    out  2*D_W  assembled result word, MSB-first; held until the next word
//  done        out  1      one-cycle pulse after the last result word
//  err         out  1      watchdog expiry pulse; tied 0 without TPU_CTRL_TIMEOUT_EN
// BEHAVIOUR
//  Reset: state=IDLE; all counters 0. Outputs busy, in_ready, data_in_x, data_in_y, load_en,
//   init, res_valid, res_data, done and err are all 0.
//  FSM: IDLE -> LOAD -> FIRE -> WAIT -> DRAIN -> DONE -> IDLE.
//  IDLE:  start=1 -> LOAD next cycle; beat_cnt, bit_cnt and word_cnt cleared. tx_ready ignored.
//  LOAD:
//   - in_ready=1 while the shifter is empty, or on the last bit cycle of the current byte
//     (back-to-back bytes, no bubble).
//   - in_valid&in_ready latches in_x/in_y. For the next D_W cycles: load_en=1, bits driven MSB first.
//   - Shifter empty with no in_valid: load_en=0 and data lines 0 (gap cycle, no bit counted).
//   - The last bit of beat BEATS-1 moves to FIRE. in_ready=0 on that cycle; extra host data is not accepted.
//   - tx_ready ignored.
//  FIRE:  init=1 for exactly one cycle -> WAIT. load_en=0.
//  WAIT:
//   - The first cycle with tx_ready=1 samples data_out_z as result bit 0 -> DRAIN.
//   - start ignored while busy=1.
//  DRAIN:
//   - One bit per cycle, shifted in MSB-first; total RES_BITS = N*N*2*D_W bits incl. the WAIT-cycle bit.
//   - tx_ready is not rechecked. A drop of tx_ready mid-stream does not stall the count.
//   - Every 2*D_W bits: res_data updated and res_valid=1 on the following cycle.
//   - After word N*N-1 -> DONE. No backpressure: a consumer must accept one word per 2*D_W cycles.
//  DONE:  done=1 one cycle -> IDLE.
//  Counters:
//   - bit_cnt wraps at D_W (LOAD) / 2*D_W (DRAIN).
//   - beat_cnt counts 0..BEATS-1; word_cnt counts 0..N*N-1. Each is sized by $clog2 of its limit.
//  rst mid-job: immediate abort to IDLE. A partial word is discarded; no done, no res_valid.
// CONFIGURATION
//  TPU_CTRL_TIMEOUT_EN defined:
//   - WAIT counts cycles. Reaching TIMEOUT with no tx_ready gives err=1 for one cycle -> IDLE,
//     with no done.
//   - The counter clears on WAIT entry.
//  Undefined: WAIT has no limit; err is constant 0; no counter is synthesised.
// TESTING (D_W=8, N=3, WORD=3 -> BEATS=9, 144 result bits, 9 words)
//  1 Reset/idle:
//    - rst pulse, then start=0 for 20 cycles -> all outputs 0 and busy=0.
//    - tx_ready toggled -> no res_valid.
//  2 Load serialisation:
//    - start, then 9 back-to-back pairs x=0xA5, y=0x3C ->
//      72 consecutive load_en cycles, x bits 10100101 and y bits 00111100 per byte.
//    - init pulses exactly once, on cycle 73.
//  3 Host gaps: in_valid low 5 cycles between beats 3 and 4 -> load_en=0 in the gap; still 72 bits total.
//  4 Drain:
//    - tx_ready rises, data_out_z carries words 0x0001..0x0009 MSB-first ->
//      9 res_valid strobes spaced 16 cycles with matching res_data.
//    - done pulses one cycle after the 9th word.
//  5 Reset mid-job:
//    - rst asserted during beat 5 -> busy=0 immediately.
//    - A following clean job produces correct results.
//  6 Watchdog (macro on, TIMEOUT=50): tx_ready held 0 -> err pulses 50 cycles after WAIT entry,
//    busy=0, done never asserted.

Source files
------------

// File: rtl/tpu_job_if.sv
// Host-side bundle of tpu_job_ctrl: job start/status, operand pair handshake and result words.
// The master modport is the host; the slave modport is the controller.
interface tpu_job_if #(
   parameter int unsigned D_W = 8
);
   logic             start;
   logic             busy;
   logic             in_valid;
   logic             in_ready;
   logic [D_W-1:0]   in_x;
   logic [D_W-1:0]   in_y;
   logic             res_valid;
   logic [2*D_W-1:0] res_data;
   logic             done;
   logic             err;

   modport master (
      output start, in_valid, in_x, in_y,
      input  busy, in_ready, res_valid, res_data, done, err
   );

   modport slave (
      input  start, in_valid, in_x, in_y,
      output busy, in_ready, res_valid, res_data, done, err
   );
endinterface

// File: rtl/tpu_job_ctrl.sv
// TinyTPU job sequencer: serialises host operand pairs MSB-first, fires the array, then
// deserialises the result stream into words. Optional WAIT watchdog: TPU_CTRL_TIMEOUT_EN.
module tpu_job_ctrl #(
   parameter int unsigned D_W     = 8,
   parameter int unsigned N       = 3,
   parameter int unsigned WORD    = 3,
   parameter int unsigned TIMEOUT = 1024
) (
   input  logic    clk,
   input  logic    rst,
   tpu_job_if.slave host,
   output logic    data_in_x,
   output logic    data_in_y,
   output logic    load_en,
   output logic    init,
   input  logic    data_out_z,
   input  logic    tx_ready
);
   localparam int unsigned BEATS = N * WORD;
   localparam int unsigned WORDS = N * N;
   localparam int unsigned RW    = 2 * D_W;
   localparam int unsigned BitW  = (RW > 1) ? $clog2(RW) : 1;
   localparam int unsigned BeatW = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int unsigned WordW = (WORDS > 1) ? $clog2(WORDS) : 1;

   localparam logic [BitW-1:0]  LoadLast  = BitW'(D_W - 1);
   localparam logic [BitW-1:0]  DrainLast = BitW'(RW - 1);
   localparam logic [BeatW-1:0] BeatLast  = BeatW'(BEATS - 1);
   localparam logic [WordW-1:0] WordLast  = WordW'(WORDS - 1);

   typedef enum logic [2:0] {StIdle, StLoad, StFire, StWait, StDrain, StDone} state_e;

   state_e           state_q, state_d;
   logic [BitW-1:0]  bit_cnt_q, bit_cnt_d;
   logic [BeatW-1:0] beat_cnt_q, beat_cnt_d;
   logic [WordW-1:0] word_cnt_q, word_cnt_d;
   logic             full_q, full_d;
   logic [D_W-1:0]   sx_q, sx_d, sy_q, sy_d;
   logic [RW-1:0]    sr_q, sr_d;
   logic [RW-1:0]    res_data_q, res_data_d;
   logic             res_valid_q, res_valid_d;
   logic             done_q, done_d;
   logic             wd_hit;

`ifdef TPU_CTRL_TIMEOUT_EN
   localparam int unsigned WdW = $clog2(TIMEOUT + 1);
   logic [WdW-1:0] wd_q;

   // Counts WAIT cycles; cleared on the FIRE cycle so it starts at 0 on WAIT entry.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wd_q <= '0;
      end else if (state_q == StWait) begin
         wd_q <= wd_q + 1'b1;
      end else begin
         wd_q <= '0;
      end
   end

   assign wd_hit = (state_q == StWait) && !tx_ready && (wd_q == WdW'(TIMEOUT - 1));
`else
   logic unused_timeout;
   assign unused_timeout = |TIMEOUT;
   assign wd_hit         = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         bit_cnt_q   <= '0;
         beat_cnt_q  <= '0;
         word_cnt_q  <= '0;
         full_q      <= 1'b0;
         sx_q        <= '0;
         sy_q        <= '0;
         sr_q        <= '0;
         res_data_q  <= '0;
         res_valid_q <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         beat_cnt_q  <= beat_cnt_d;
         word_cnt_q  <= word_cnt_d;
         full_q      <= full_d;
         sx_q        <= sx_d;
         sy_q        <= sy_d;
         sr_q        <= sr_d;
         res_data_q  <= res_data_d;
         res_valid_q <= res_valid_d;
         done_q      <= done_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      bit_cnt_d     = bit_cnt_q;
      beat_cnt_d    = beat_cnt_q;
      word_cnt_d    = word_cnt_q;
      full_d        = full_q;
      sx_d          = sx_q;
      sy_d          = sy_q;
      sr_d          = sr_q;
      res_data_d    = res_data_q;
      res_valid_d   = 1'b0;
      done_d        = 1'b0;
      host.in_ready = 1'b0;
      load_en       = 1'b0;
      data_in_x     = 1'b0;
      data_in_y     = 1'b0;
      init          = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (host.start) begin
               state_d    = StLoad;
               bit_cnt_d  = '0;
               beat_cnt_d = '0;
               word_cnt_d = '0;
               full_d     = 1'b0;
            end
         end
         StLoad: begin
            // Refill on the last bit of a byte keeps beats back-to-back; never after the final beat.
            host.in_ready = !full_q ||
                            ((bit_cnt_q == LoadLast) && (beat_cnt_q != BeatLast));
            if (full_q) begin
               load_en   = 1'b1;
               data_in_x = sx_q[D_W-1];
               data_in_y = sy_q[D_W-1];
               sx_d      = sx_q << 1;
               sy_d      = sy_q << 1;
               bit_cnt_d = bit_cnt_q + 1'b1;
               if (bit_cnt_q == LoadLast) begin
                  bit_cnt_d = '0;
                  full_d    = 1'b0;
                  if (beat_cnt_q == BeatLast) begin
                     state_d = StFire;
                  end else begin
                     beat_cnt_d = beat_cnt_q + 1'b1;
                  end
               end
            end
            if (host.in_valid && host.in_ready) begin
               sx_d   = host.in_x;
               sy_d   = host.in_y;
               full_d = 1'b1;
            end
         end
         StFire: begin
            init    = 1'b1;
            state_d = StWait;
         end
         StWait: begin
            if (tx_ready) begin
               sr_d       = {sr_q[RW-2:0], data_out_z};
               bit_cnt_d  = BitW'(1);
               word_cnt_d = '0;
               state_d    = StDrain;
            end else if (wd_hit) begin
               state_d = StIdle;
            end
         end
         StDrain: begin
            sr_d      = {sr_q[RW-2:0], data_out_z};
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == DrainLast) begin
               bit_cnt_d   = '0;
               res_data_d  = {sr_q[RW-2:0], data_out_z};
               res_valid_d = 1'b1;
               if (word_cnt_q == WordLast) begin
                  state_d = StDone;
               end else begin
                  word_cnt_d = word_cnt_q + 1'b1;
               end
            end
         end
         StDone: begin
            done_d  = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   assign host.busy      = (state_q != StIdle);
   assign host.res_valid = res_valid_q;
   assign host.res_data  = res_data_q;
   assign host.done      = done_q;
   assign host.err       = wd_hit;
endmodule
